// File: rtl/frogger_pkg.sv
// Shared Frogger playfield constants and small elaboration-time helpers.
package frogger_pkg;

  // Ceiling log2, used to size tile-coordinate buses.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;
  localparam int XW     = clog2(GRID_W);
  localparam int YW     = clog2(GRID_H);

  // Extract field idx (w bits wide) from a packed per-lane parameter vector.
  function automatic int unsigned field_u(input logic [255:0] vec, input int idx, input int w);
    logic [255:0] m;
    m = (256'd1 << w) - 256'd1;
    return 32'((vec >> (idx * w)) & m);
  endfunction

endpackage

// File: rtl/frogger_lane_mover.sv
// One traffic lane: tick divider scaled by level plus a wrapping offset.
module frogger_lane_mover #(
  parameter int                GRID_W    = frogger_pkg::GRID_W,
  parameter int                XW        = frogger_pkg::clog2(GRID_W),
  parameter int                PERIOD_W  = 8,
  parameter int                MAX_SHIFT = 3,
  parameter logic [PERIOD_W-1:0] BASE    = 1,
  parameter bit                DIR       = 1'b1,
  parameter logic [XW-1:0]     INIT      = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          freeze,
  input  logic          restart,
  input  logic [6:0]    level,
  output logic [XW-1:0] offset
);

  logic [6:0]          shift;
  logic [PERIOD_W-1:0] shifted;
  logic [PERIOD_W-1:0] eff;
  logic [PERIOD_W-1:0] cnt;
  logic [XW-1:0]       step;

  // Level-scaled period, never below one tick.
  always_comb begin
    shift   = (level > 7'(MAX_SHIFT)) ? 7'(MAX_SHIFT) : level;
    shifted = BASE >> shift;
    eff     = (shifted == '0) ? PERIOD_W'(1) : shifted;
  end

  // Next offset one tile along the lane direction, wrapping at the edges.
  always_comb begin
    step = offset;
    if (DIR) step = (offset == XW'(GRID_W - 1)) ? '0 : offset + XW'(1);
    else     step = (offset == '0) ? XW'(GRID_W - 1) : offset - XW'(1);
  end

  // Restart beats freeze beats tick; >= tolerates a period shrinking mid-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      offset <= INIT;
    end else if (restart) begin
      cnt    <= '0;
      offset <= INIT;
    end else if (!freeze && tick) begin
      if (cnt >= eff - PERIOD_W'(1)) begin
        cnt    <= '0;
        offset <= step;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/frogger_lane_engine.sv
// Frogger traffic engine: per-lane movers, tile hit test, collision edge detect.
module frogger_lane_engine #(
  parameter int NUM_LANES     = 4,
  parameter int CARS_PER_LANE = 2,
  parameter int GRID_W        = frogger_pkg::GRID_W,
  parameter int GRID_H        = frogger_pkg::GRID_H,
  parameter int LANE_ROW_0    = 8,
  parameter int PERIOD_W      = 8,
  parameter logic [NUM_LANES*PERIOD_W-1:0] BASE_PERIOD = {8'd16, 8'd8, 8'd4, 8'd2},
  parameter logic [NUM_LANES-1:0]          DIR_MASK    = 4'b0101,
  parameter int MAX_SHIFT     = 3,
  parameter int XW            = frogger_pkg::clog2(GRID_W),
  parameter int YW            = frogger_pkg::clog2(GRID_H),
  parameter logic [NUM_LANES*XW-1:0]       INIT_OFFSET = '0
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Tick,
  input  logic          i_Freeze,
  input  logic          i_Restart,
  input  logic [6:0]    i_Level,
  input  logic [XW-1:0] i_Frog_X,
  input  logic [YW-1:0] i_Frog_Y,
  input  logic [XW-1:0] i_Query_X,
  input  logic [YW-1:0] i_Query_Y,
  output logic          o_Car_Hit,
  output logic          o_Car_Dir,
  output logic          o_Collided,
  output logic          o_Collide_Pulse
);
  import frogger_pkg::*;

  localparam int SPACING = GRID_W / CARS_PER_LANE;

  logic [NUM_LANES-1:0][XW-1:0]                    offset;
  logic [NUM_LANES-1:0][CARS_PER_LANE-1:0][XW-1:0] car_x;
  logic q_hit, q_dir, f_hit;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    frogger_lane_mover #(
      .GRID_W   (GRID_W),
      .XW       (XW),
      .PERIOD_W (PERIOD_W),
      .MAX_SHIFT(MAX_SHIFT),
      .BASE     (PERIOD_W'(field_u(256'(BASE_PERIOD), k, PERIOD_W))),
      .DIR      (DIR_MASK[k]),
      .INIT     (XW'(field_u(256'(INIT_OFFSET), k, XW)))
    ) u_mover (
      .clk    (i_Clk),
      .rst_n  (i_Rst_L),
      .tick   (i_Tick),
      .freeze (i_Freeze),
      .restart(i_Restart),
      .level  (i_Level),
      .offset (offset[k])
    );

    // Both addends are below GRID_W, so a single conditional subtract wraps.
    for (genvar j = 0; j < CARS_PER_LANE; j++) begin : g_car
      logic [XW:0] sum;
      assign sum         = {1'b0, offset[k]} + (XW+1)'(j * SPACING);
      assign car_x[k][j] = (sum >= (XW+1)'(GRID_W)) ? XW'(sum - (XW+1)'(GRID_W)) : sum[XW-1:0];
    end
  end

  // OR-trees for render query and frog overlap; only lane-band rows can match.
  always_comb begin
    q_hit = 1'b0;
    q_dir = 1'b0;
    f_hit = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      for (int j = 0; j < CARS_PER_LANE; j++) begin
        if (i_Query_Y == YW'(LANE_ROW_0 + k) && car_x[k][j] == i_Query_X) begin
          q_hit = 1'b1;
          q_dir = DIR_MASK[k];
        end
        if (i_Frog_Y == YW'(LANE_ROW_0 + k) && car_x[k][j] == i_Frog_X) f_hit = 1'b1;
      end
    end
  end

  // Output registers; o_Collided doubles as the previous-overlap state for the edge pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Car_Hit       <= 1'b0;
      o_Car_Dir       <= 1'b0;
      o_Collided      <= 1'b0;
      o_Collide_Pulse <= 1'b0;
    end else begin
      o_Car_Hit       <= q_hit;
      o_Car_Dir       <= q_dir;
      o_Collided      <= f_hit;
      o_Collide_Pulse <= f_hit & ~o_Collided;
    end
  end

endmodule

// File: doc/frogger_lane_engine.md
# frogger_lane_engine

Parametrised traffic engine for the Frogger playfield. It owns NUM_LANES lanes of cars. Each lane has its own period, direction and start offset, and its speed scales with the game level. The block sits between frogger_game's frame tick and its renderer and lives logic. It answers per-tile render queries, and reports frog/car overlap both as a level and as a one-shot edge pulse.

## Interface
- NUM_LANES, 4: number of lanes; lane k occupies grid row LANE_ROW_0+k.
- CARS_PER_LANE, 2: cars per lane, evenly spaced by SPACING = GRID_W/CARS_PER_LANE. Must divide GRID_W.
- GRID_W, 20: playfield width in tiles.
- GRID_H, 15: playfield height in tiles.
- LANE_ROW_0, 8: grid row of lane 0.
- PERIOD_W, 8: width of one lane period field.
- BASE_PERIOD, {8'd16,8'd8,8'd4,8'd2}: packed per-lane base period in ticks, lane 0 in the LSBs.
- DIR_MASK, 4'b0101: per-lane direction; 1 = rightwards (+x), 0 = leftwards.
- INIT_OFFSET, 0: packed per-lane start offset, XW bits each, where XW = clog2(GRID_W).
- MAX_SHIFT, 3: cap on the level-derived period shift.

Ports:
- i_Clk, in, 1: system clock.
- i_Rst_L, in, 1: asynchronous, active-low reset.
- i_Tick, in, 1: one-cycle movement strobe (frame tick).
- i_Freeze, in, 1: holds all lane state.
- i_Restart, in, 1: synchronous reload of the initial lane state.
- i_Level, in, 7: current level.
- i_Frog_X, in, XW: frog column.
- i_Frog_Y, in, YW: frog row.
- i_Query_X, in, XW: render query column.
- i_Query_Y, in, YW: render query row.
- o_Car_Hit, out, 1: the query tile holds a car.
- o_Car_Dir, out, 1: direction of the lane that was hit.
- o_Collided, out, 1: frog overlaps a car (level output).
- o_Collide_Pulse, out, 1: one-cycle pulse on a rising overlap.

## Operation
- **Per-lane state:** XW-bit offset and PERIOD_W-bit tick counter.
- **Car positions:** car j of lane k is at x = offset_k + j·SPACING.
  - If the sum is ≥ GRID_W, subtract GRID_W once. Both operands are < GRID_W, so one subtract suffices.
- **Effective period:** eff_k = BASE_PERIOD_k >> min(i_Level, MAX_SHIFT), floored at 1.
- **On i_Tick, when not frozen and not restarting:**
  - If counter_k ≥ eff_k−1: clear the counter and step the offset by one tile in the lane's direction.
  - Otherwise: increment the counter.
  - The ≥ compare handles a level increase mid-count; the lane advances on the next tick.
- **Wrap-around:** rightwards GRID_W−1 → 0; leftwards 0 → GRID_W−1.
- **Priority:** i_Restart > i_Freeze > i_Tick.
  - Restart loads INIT_OFFSET and zeroes the counters, regardless of i_Tick.
  - Freeze holds the counters and offsets.
- **Render query:** a hit requires i_Query_Y in [LANE_ROW_0, LANE_ROW_0+NUM_LANES) and some car x = i_Query_X.
  - Rows outside the lane band, or outside the grid, give hit = 0 and dir = 0.
- **Collision:** overlap = the same test applied to the frog position.
  - o_Collided = registered overlap.
  - o_Collide_Pulse = overlap & ~overlap_prev.
  - overlap_prev resets to 0, so a frog already on a car after reset produces one pulse.

## Timing
- **Reset:** all outputs and counters reset to 0; offsets reset to INIT_OFFSET. Reset is asynchronous and does not need a clock edge.
- **Movement:** lane state updates on the edge that samples i_Tick. Query and collision outputs reflect the new positions one cycle later.
- **Query and collision latency:** exactly 1 cycle from input to registered output. Inputs may change every cycle; the design is fully pipelined with no stalls.
- **Simultaneous tick and frog move:** collision is evaluated against the registered offsets of that cycle, i.e. the pre-move positions.
- **Reset mid-count:** the partial count is discarded.

## Structure
- **Shared package frogger_pkg:**
  - GRID_W, GRID_H, XW/YW width constants.
  - clog2 function.
  - Packed-vector slice helpers.
- **Sub-module frogger_lane_mover:** one instance per lane (generate loop).
  - Holds the counter, the offset, the eff-period computation, and the wrap/direction step.
  - Outputs its offset.
- **Top level:** hit/overlap OR-trees, output registers, edge detector.

## Test plan
- **Reset state:** release i_Rst_L, query (10,8) → o_Car_Hit=1 and o_Car_Dir=1 next cycle; query (5,8) → 0; query (0,3) → 0.
- **Movement and wrap:** level 0.
  - 2 ticks → lane 0 cars at x=1 and 11.
  - 4 ticks → lane 1 (leftwards) offset 19, so query (19,9) hits.
- **Level scaling:**
  - Level 1 → lane 0 moves every tick.
  - Level 5 → lane 3 eff = 16>>3 = 2, lane 0 eff floored to 1.
- **Collision:** frog at (0,8) after reset.
  - o_Collided=1 one cycle later and stays 1.
  - o_Collide_Pulse fires exactly one cycle.
  - Move to (0,7) then back to (0,8) → a second single pulse.
- **Priority:** i_Freeze + i_Tick ×5 → offsets unchanged; i_Restart + i_Tick → offsets INIT, counters 0.
- **Asynchronous reset:** drop i_Rst_L between clock edges while o_Collided=1 → o_Collided=0 immediately, with no clock edge.
